// File: rtl/ix_scoreboard_pkg.sv
// Shared issue-stage types: the writeback-to-issue register write bundle and
// scoreboard sizing constants.
package ix_scoreboard_pkg;

  localparam int REG_WIDTH    = 5;
  localparam int SB_CNT_WIDTH = 2;

  typedef struct packed {
    logic                 wr_en;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          wr_data;
  } wb_ix_inf_t;

endpackage

// File: rtl/ix_scoreboard_counter_bank.sv
// Per-register pending-write counters: one increment (issue) and two
// decrement sources (writeback, squash) per register per cycle.
module sb_counter_bank
  import ix_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REGS-1:0]                 i_inc,
  input  logic [NUM_REGS-1:0]                 i_dec_wb,
  input  logic [NUM_REGS-1:0]                 i_dec_sq,
  output logic [NUM_REGS-1:0][CNT_WIDTH-1:0]  o_cnt,
  output logic [NUM_REGS-1:0]                 o_sat,
  output logic                                o_idle,
  output logic                                o_underflow
);

  localparam int CW1 = CNT_WIDTH + 1;

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] w_cnt_nxt;
  logic [NUM_REGS-1:0]                w_uflow;
  logic [CW1-1:0]                     w_sum;
  logic [CW1-1:0]                     w_dec;
  logic                               r_err;

  // One extra bit holds cnt+inc when a saturated counter is also retiring.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_uflow   = '0;
    w_sum     = '0;
    w_dec     = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_sum = {1'b0, r_cnt[i]} + CW1'(i_inc[i]);
      w_dec = CW1'(i_dec_wb[i]) + CW1'(i_dec_sq[i]);
      if (w_dec > w_sum) begin
        w_uflow[i]   = 1'b1;
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = CNT_WIDTH'(w_sum - w_dec);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (|w_uflow) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (w_uflow == '0)
        else $warning("sb_counter_bank: pending counter underflow, mask %h", w_uflow);
    end
  end

  always_comb begin
    o_sat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) o_sat[i] = (r_cnt[i] == '1);
  end

  assign o_cnt       = r_cnt;
  assign o_idle      = (r_cnt == '0);
  assign o_underflow = r_err;

endmodule

// File: rtl/ix_scoreboard.sv
// Issue-stage scoreboard: architectural register file with same-cycle WB
// bypass, pending-write tracking and RAW/saturation stall generation.
module ix_scoreboard
  import ix_scoreboard_pkg::*;
#(
  parameter int CNT_WIDTH = SB_CNT_WIDTH,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  wb_ix_inf_t           wb_ix_inf,
  input  logic                 issue_valid,
  input  logic [REG_WIDTH-1:0] issue_rs1,
  input  logic [REG_WIDTH-1:0] issue_rs2,
  input  logic                 issue_rs1_used,
  input  logic                 issue_rs2_used,
  input  logic [REG_WIDTH-1:0] issue_rd,
  input  logic                 issue_rd_write,
  input  logic                 squash_valid,
  input  logic [REG_WIDTH-1:0] squash_rd,
  output logic [31:0]          rs1_data,
  output logic [31:0]          rs2_data,
  output logic                 ix_stall,
  output logic                 ix_idle,
  output logic                 sb_error
);

  logic [31:0]                        r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]                w_inc, w_dec_wb, w_dec_sq, w_sat_vec;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] w_cnt;
  logic [CNT_WIDTH-1:0]               w_cnt_rs1, w_cnt_rs2;
  logic                               w_wb_hit1, w_wb_hit2;
  logic                               w_raw1, w_raw2, w_sat, w_fire;

  always_ff @(posedge clk) begin
    if (wb_ix_inf.wr_en && wb_ix_inf.rd != '0) r_regs[wb_ix_inf.rd] <= wb_ix_inf.wr_data;
  end

  assign w_wb_hit1 = wb_ix_inf.wr_en && (wb_ix_inf.rd == issue_rs1);
  assign w_wb_hit2 = wb_ix_inf.wr_en && (wb_ix_inf.rd == issue_rs2);
  assign rs1_data  = (issue_rs1 == '0) ? '0 : (w_wb_hit1 ? wb_ix_inf.wr_data : r_regs[issue_rs1]);
  assign rs2_data  = (issue_rs2 == '0) ? '0 : (w_wb_hit2 ? wb_ix_inf.wr_data : r_regs[issue_rs2]);

  always_comb begin
    w_dec_wb = '0;
    w_dec_sq = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_dec_wb[r] = wb_ix_inf.wr_en && (wb_ix_inf.rd == REG_WIDTH'(r));
      w_dec_sq[r] = squash_valid && (squash_rd == REG_WIDTH'(r));
    end
  end

  // A last outstanding write retiring this cycle is covered by the bypass.
  assign w_cnt_rs1 = w_cnt[issue_rs1];
  assign w_cnt_rs2 = w_cnt[issue_rs2];
  assign w_raw1 = issue_rs1_used && (issue_rs1 != '0) && (w_cnt_rs1 != '0) &&
                  !((w_cnt_rs1 == CNT_WIDTH'(1)) && w_wb_hit1);
  assign w_raw2 = issue_rs2_used && (issue_rs2 != '0) && (w_cnt_rs2 != '0) &&
                  !((w_cnt_rs2 == CNT_WIDTH'(1)) && w_wb_hit2);
  assign w_sat  = issue_rd_write && (issue_rd != '0) && w_sat_vec[issue_rd] &&
                  !w_dec_wb[issue_rd] && !w_dec_sq[issue_rd];

  assign ix_stall = issue_valid && (w_raw1 || w_raw2 || w_sat);
  assign w_fire   = issue_valid && !ix_stall;

  always_comb begin
    w_inc = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++)
      w_inc[r] = w_fire && issue_rd_write && (issue_rd == REG_WIDTH'(r));
  end

  sb_counter_bank #(
    .NUM_REGS  (NUM_REGS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_inc),
    .i_dec_wb    (w_dec_wb),
    .i_dec_sq    (w_dec_sq),
    .o_cnt       (w_cnt),
    .o_sat       (w_sat_vec),
    .o_idle      (ix_idle),
    .o_underflow (sb_error)
  );

endmodule

// File: tb/tb_ix_scoreboard.sv
// Directed and randomized checks of ix_scoreboard against an integer-count
// reference model of pending register writes.
module tb_ix_scoreboard;
  import ix_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  wb_ix_inf_t  wb;
  logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_write, squash_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, squash_rd;
  logic [31:0] rs1_data, rs2_data;
  logic        ix_stall, ix_idle, sb_error;

  always #5 clk = ~clk;

  ix_scoreboard #(.CNT_WIDTH(2), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .wb_ix_inf(wb),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_write(issue_rd_write),
    .squash_valid(squash_valid), .squash_rd(squash_rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ix_stall(ix_stall), .ix_idle(ix_idle), .sb_error(sb_error)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_cnt [32];
  logic [31:0] m_reg [32];
  bit          m_known [32];
  bit          m_err;
  logic [31:0] x4_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  function automatic int m_dec(input int r);
    return int'(wb.wr_en && wb.rd == 5'(r)) + int'(squash_valid && squash_rd == 5'(r));
  endfunction

  function automatic bit m_raw(input bit used, input int rs);
    if (!used || rs == 0 || m_cnt[rs] == 0) return 1'b0;
    return !(m_cnt[rs] == 1 && wb.wr_en && wb.rd == 5'(rs));
  endfunction

  function automatic bit m_stall();
    bit sat;
    sat = issue_rd_write && issue_rd != 0 && m_cnt[issue_rd] == 3 && m_dec(int'(issue_rd)) == 0;
    return issue_valid && (m_raw(issue_rs1_used, int'(issue_rs1)) ||
                           m_raw(issue_rs2_used, int'(issue_rs2)) || sat);
  endfunction

  function automatic bit m_idle();
    foreach (m_cnt[r]) if (m_cnt[r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk_rs(input string tag, input logic [4:0] rs, input logic [31:0] obs);
    if (rs == 0)                       chk(tag, obs, 32'h0);
    else if (wb.wr_en && wb.rd == rs)  chk(tag, obs, wb.wr_data);
    else if (m_known[rs])              chk(tag, obs, m_reg[rs]);
  endtask

  task automatic begin_cyc();
    @(negedge clk);
    rst = 1'b1; wb = '0;
    issue_valid = 0; issue_rs1_used = 0; issue_rs2_used = 0; issue_rd_write = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; squash_valid = 0; squash_rd = 0;
  endtask

  task automatic check_all();
    #1;
    chk("stall", ix_stall, m_stall());
    chk("idle", ix_idle, m_idle());
    chk("sb_error", sb_error, m_err);
    chk_rs("rs1_data", issue_rs1, rs1_data);
    chk_rs("rs2_data", issue_rs2, rs2_data);
  endtask

  task automatic end_cyc();
    bit fire;
    int n;
    fire = issue_valid && !m_stall();
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        n = m_cnt[r] + int'(fire && issue_rd_write && issue_rd == 5'(r)) - m_dec(r);
        if (n < 0) begin n = 0; m_err = 1'b1; end
        m_cnt[r] = n;
      end
    end else begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_err = 1'b0;
    end
    if (wb.wr_en && wb.rd != 0) begin m_reg[wb.rd] = wb.wr_data; m_known[wb.rd] = 1'b1; end
    @(posedge clk);
  endtask

  task automatic set_issue_rd(input int rd);
    issue_valid = 1; issue_rd_write = 1; issue_rd = 5'(rd);
  endtask

  task automatic set_wb(input int rd, input logic [31:0] d);
    wb.wr_en = 1; wb.rd = 5'(rd); wb.wr_data = d;
  endtask

  initial begin
    int cand [$];
    foreach (m_cnt[r]) begin m_cnt[r] = 0; m_known[r] = 0; m_reg[r] = '0; end
    m_err = 0;
    begin_cyc(); rst = 0; @(posedge clk);
    begin_cyc(); rst = 0; @(posedge clk);
    // Preload every register while held in reset so no counter is touched.
    for (int r = 1; r < 32; r++) begin
      begin_cyc(); rst = 0; set_wb(r, $urandom); end_cyc();
    end
    x4_val = m_reg[4];

    begin_cyc(); check_all();
    chk("reset_idle", ix_idle, 1'b1); chk("reset_stall", ix_stall, 1'b0); end_cyc();

    begin_cyc(); set_issue_rd(5); check_all(); end_cyc();
    begin_cyc(); issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1; check_all();
    chk("raw_stall", ix_stall, 1'b1); chk("busy", ix_idle, 1'b0); end_cyc();
    begin_cyc(); issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1; set_wb(5, 32'hDEADBEEF);
    check_all(); chk("bypass_stall", ix_stall, 1'b0); chk("bypass_data", rs1_data, 32'hDEADBEEF); end_cyc();

    for (int i = 0; i < 3; i++) begin
      begin_cyc(); set_issue_rd(7); check_all(); chk("rd7_issue", ix_stall, 1'b0); end_cyc();
    end
    begin_cyc(); set_issue_rd(7); check_all(); chk("sat_stall", ix_stall, 1'b1); end_cyc();
    begin_cyc(); set_issue_rd(7); set_wb(7, 32'h0000_0777); check_all();
    chk("sat_release", ix_stall, 1'b0); end_cyc();
    begin_cyc(); set_issue_rd(7); check_all(); chk("sat_hold3", ix_stall, 1'b1); end_cyc();
    for (int i = 0; i < 3; i++) begin
      begin_cyc(); set_wb(7, 32'h7000 + 32'(i)); check_all(); end_cyc();
    end

    begin_cyc(); issue_valid = 1; issue_rs1 = 0; issue_rs1_used = 1; issue_rd = 0; issue_rd_write = 1;
    set_wb(0, 32'hBAD0BAD0); check_all();
    chk("x0_stall", ix_stall, 1'b0); chk("x0_data", rs1_data, 32'h0); chk("x0_idle", ix_idle, 1'b1); end_cyc();
    begin_cyc(); check_all(); chk("x0_idle_after", ix_idle, 1'b1); end_cyc();

    for (int i = 0; i < 2; i++) begin begin_cyc(); set_issue_rd(9); check_all(); end_cyc(); end
    begin_cyc(); set_wb(9, 32'h9999_0009); squash_valid = 1; squash_rd = 9; check_all(); end_cyc();
    begin_cyc(); check_all(); chk("wb_sq_idle", ix_idle, 1'b1); chk("wb_sq_err", sb_error, 1'b0); end_cyc();

    begin_cyc(); squash_valid = 1; squash_rd = 3; check_all(); end_cyc();
    for (int i = 0; i < 3; i++) begin
      begin_cyc(); check_all(); chk("uflow_sticky", sb_error, 1'b1); end_cyc();
    end
    begin_cyc(); rst = 0; check_all(); end_cyc();
    begin_cyc(); check_all(); chk("uflow_cleared", sb_error, 1'b0); end_cyc();

    for (int i = 0; i < 2; i++) begin begin_cyc(); set_issue_rd(4); check_all(); end_cyc(); end
    begin_cyc(); issue_valid = 1; issue_rs1 = 4; issue_rs1_used = 1; issue_rs2 = 4; issue_rs2_used = 1;
    rst = 0; check_all(); chk("pre_rst_stall", ix_stall, 1'b1); end_cyc();
    begin_cyc(); issue_valid = 1; issue_rs1 = 4; issue_rs1_used = 1; issue_rs2 = 4; issue_rs2_used = 1;
    check_all(); chk("rst_stall", ix_stall, 1'b0); chk("rst_idle", ix_idle, 1'b1);
    chk("x4_retained", rs2_data, x4_val); end_cyc();

    for (int c = 0; c < 1500; c++) begin
      begin_cyc();
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0)
        set_wb(cand[$urandom_range(0, cand.size() - 1)], $urandom);
      else if ($urandom_range(0, 9) == 0)
        set_wb(0, $urandom);
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] - int'(wb.wr_en && wb.rd == 5'(r)) > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 3) == 0) begin
        squash_valid = 1; squash_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_rs1      = 5'($urandom_range(0, 7));
      issue_rs2      = 5'($urandom_range(0, 7));
      issue_rs1_used = $urandom_range(0, 1) == 1;
      issue_rs2_used = $urandom_range(0, 1) == 1;
      issue_rd       = 5'($urandom_range(0, 7));
      issue_rd_write = $urandom_range(0, 4) != 0;
      check_all();
      end_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
